// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: one outstanding CPU access, lane steering, extension, wait timeout.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of aligning them.
module dmem_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RWAIT, RESP} state_t;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_wen;
    logic [31:2] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [2:0]  r_op;
    logic [1:0]  r_off;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [9:0]  r_cnt;

    logic        w_illegal;
    logic        w_reject;
    logic [1:0]  w_off;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_accept;
    logic        w_timeout;
    logic        w_capture;

    // Request decode: legality, effective lane offset, strobes and replicated store data
    always_comb begin
        w_illegal = (req_op == 3'b011) || (req_op[2:1] == 2'b11);
        case (req_op[1:0])
            2'b00: begin
                w_off   = req_addr[1:0];
                w_strb  = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_off   = {req_addr[1], 1'b0};
                w_strb  = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_off   = 2'b00;
                w_strb  = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_reject   = w_illegal || w_misalign;
`else
    assign w_reject   = w_illegal;
`endif

    // Load lane selection and extension from the returned word
    always_comb begin
        w_byte = mem_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_op)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_timeout = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_reject ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    w_next = r_wen ? RESP : RWAIT;
                end else if (r_cnt == TO_LAST) begin
                    w_next    = RESP;
                    w_timeout = 1'b1;
                end
            end
            RWAIT: begin
                if (mem_rvalid) begin
                    w_next    = RESP;
                    w_capture = 1'b1;
                end else if (r_cnt == TO_LAST) begin
                    w_next    = RESP;
                    w_timeout = 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_op    <= '0;
            r_off   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // The wait counter restarts whenever the state changes, i.e. on entry to REQ or RWAIT
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == REQ) || (r_state == RWAIT)) begin
                r_cnt <= r_cnt + 10'd1;
            end
            if (w_accept) begin
                r_err <= w_reject;
                if (w_reject) begin
                    r_rdata <= '0;
                end else begin
                    r_wen   <= req_wen;
                    r_addr  <= req_addr[31:2];
                    r_wdata <= req_wen ? w_wdata : 32'd0;
                    r_wstrb <= req_wen ? w_strb : 4'b0000;
                    r_op    <= req_op;
                    r_off   <= w_off;
                end
            end
            if (w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end
            if (w_capture) begin
                r_rdata <= w_ext;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign mem_valid = (r_state == REQ);
    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = (r_state == RESP) && r_err;
    assign rsp_rdata = r_rdata;
    assign mem_wen   = r_wen;
    assign mem_addr  = {r_addr, 2'b00};
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: feature tasks drive accesses, a monitor checks every response.
module tb_dmem_lsu;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    dmem_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Response monitor: every rsp_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid err=%0b rdata=%h, required no response", rsp_err, rsp_rdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (rsp_err !== e.err || (e.chk && rsp_rdata !== e.rdata)) begin
                    errors++;
                    $display("FAIL rsp: got err=%0b rdata=%h, required err=%0b rdata=%h (chk=%0b)",
                             rsp_err, rsp_rdata, e.err, e.rdata, e.chk);
                end
            end
        end
    end

    task automatic push(input logic err, input logic chk, input logic [31:0] rd);
        exp_t e;
        e.err = err; e.chk = chk; e.rdata = rd;
        sb_q.push_back(e);
    endtask

    // Drives one access and plays the memory side; returns latency and observed bus fields
    task automatic issue(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rword,
                         input int rdy_wait, input int rv_wait,
                         output int lat, output int mv, output logic [31:0] o_addr,
                         output logic [31:0] o_wdata, output logic [3:0] o_strb,
                         output logic o_wen, output logic stable);
        int rw;
        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_op = op; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; mv = 0; rw = 0; stable = 1'b1;
        o_addr = '0; o_wdata = '0; o_strb = '0; o_wen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
            if (rsp_valid) break;
            if (mem_valid) begin
                if (mv == 0) begin
                    o_addr = mem_addr; o_wdata = mem_wdata; o_strb = mem_wstrb; o_wen = mem_wen;
                end else if (o_addr !== mem_addr || o_wdata !== mem_wdata ||
                             o_strb !== mem_wstrb || o_wen !== mem_wen) begin
                    stable = 1'b0;
                end
                mem_rvalid = 1'b1;
                if (mv == rdy_wait) mem_ready = 1'b1;
                mv++;
            end else if (mv > 0 && !wen) begin
                if (rw == rv_wait) begin
                    mem_rvalid = 1'b1; mem_rdata = rword;
                end
                rw++;
            end
            @(negedge clk);
            lat++;
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        if (!rsp_valid) lat = -1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_valid, rsp_valid, rsp_err, mem_wen} !== 4'b0 || mem_wstrb !== 4'b0 ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0 || rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got mv=%0b rv=%0b err=%0b wen=%0b strb=%b addr=%h wd=%h rd=%h, required all 0",
                     mem_valid, rsp_valid, rsp_err, mem_wen, mem_wstrb, mem_addr, mem_wdata, rsp_rdata);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %0b, required 1", req_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_store;
        int lat, mv; logic [31:0] a, d; logic [3:0] s; logic w, st;
        push(1'b0, 1'b0, 32'd0);
        issue(1'b1, 3'b000, 32'h80000003, 32'h000000AB, 32'd0, 0, 0, lat, mv, a, d, s, w, st);
        checks++;
        if (a !== 32'h80000000 || s !== 4'b1000 || d !== 32'hABABABAB || w !== 1'b1 || lat != 2) begin
            errors++;
            $display("FAIL store_byte: got addr=%h strb=%b wd=%h wen=%0b lat=%0d, required 80000000 1000 ABABABAB 1 2",
                     a, s, d, w, lat);
        end
        push(1'b0, 1'b0, 32'd0);
        issue(1'b1, 3'b001, 32'h00000012, 32'h1234BEEF, 32'd0, 0, 0, lat, mv, a, d, s, w, st);
        checks++;
        if (a !== 32'h00000010 || s !== 4'b1100 || d !== 32'hBEEFBEEF || lat != 2) begin
            errors++;
            $display("FAIL store_half: got addr=%h strb=%b wd=%h lat=%0d, required 00000010 1100 BEEFBEEF 2", a, s, d, lat);
        end
        push(1'b0, 1'b0, 32'd0);
        issue(1'b1, 3'b010, 32'h00000100, 32'hCAFE0123, 32'd0, 0, 0, lat, mv, a, d, s, w, st);
        checks++;
        if (a !== 32'h00000100 || s !== 4'b1111 || d !== 32'hCAFE0123 || lat != 2) begin
            errors++;
            $display("FAIL store_word: got addr=%h strb=%b wd=%h lat=%0d, required 00000100 1111 CAFE0123 2", a, s, d, lat);
        end
    endtask

    task automatic test_load_ext;
        int lat, mv; logic [31:0] a, d; logic [3:0] s; logic w, st;
        logic [2:0]  ops [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
        logic [31:0] adr [4] = '{32'h80000002, 32'h80000002, 32'h80000002, 32'h00000000};
        logic [31:0] wrd [4] = '{32'h12F45678, 32'h12F45678, 32'h12F45678, 32'h00008001};
        logic [31:0] exv [4] = '{32'hFFFFFFF4, 32'h000000F4, 32'h000012F4, 32'hFFFF8001};
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 1'b1, exv[i]);
            issue(1'b0, ops[i], adr[i], 32'd0, wrd[i], 0, 0, lat, mv, a, d, s, w, st);
            checks++;
            if (lat != 3 || w !== 1'b0 || s !== 4'b0000 || a !== {adr[i][31:2], 2'b00}) begin
                errors++;
                $display("FAIL load_bus[%0d]: got lat=%0d wen=%0b strb=%b addr=%h, required 3 0 0000 %h",
                         i, lat, w, s, a, {adr[i][31:2], 2'b00});
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL rdata_hold: got rv=%0b rdata=%h, required 0 FFFF8001", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_stall_timeout;
        int lat, mv; logic [31:0] a, d; logic [3:0] s; logic w, st;
        push(1'b0, 1'b0, 32'd0);
        issue(1'b1, 3'b010, 32'h00000040, 32'h55AA33CC, 32'd0, 5, 0, lat, mv, a, d, s, w, st);
        checks++;
        if (mv != 6 || st !== 1'b1 || lat != 7) begin
            errors++;
            $display("FAIL stall: got mv_cycles=%0d stable=%0b lat=%0d, required 6 1 7", mv, st, lat);
        end
        push(1'b1, 1'b1, 32'd0);
        issue(1'b0, 3'b010, 32'h00000044, 32'd0, 32'h11111111, 0, 1000, lat, mv, a, d, s, w, st);
        checks++;
        if (lat != 2 + TO) begin
            errors++;
            $display("FAIL rwait_timeout_lat: got %0d, required %0d", lat, 2 + TO);
        end
        push(1'b1, 1'b1, 32'd0);
        issue(1'b1, 3'b010, 32'h00000048, 32'h1, 32'd0, 1000, 0, lat, mv, a, d, s, w, st);
        checks++;
        if (mv != TO || lat != 1 + TO || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL req_timeout: got mv_cycles=%0d lat=%0d mv_now=%0b, required %0d %0d 0",
                     mv, lat, mem_valid, TO, 1 + TO);
        end
    endtask

    task automatic test_misalign;
        int lat, mv; logic [31:0] a, d; logic [3:0] s; logic w, st;
`ifdef DMEM_MISALIGN_TRAP_EN
        push(1'b1, 1'b1, 32'd0);
        issue(1'b0, 3'b010, 32'h80000002, 32'd0, 32'hCAFEF00D, 0, 0, lat, mv, a, d, s, w, st);
        checks++;
        if (mv != 0 || lat != 1) begin
            errors++;
            $display("FAIL misalign_trap: got mv_cycles=%0d lat=%0d, required 0 1", mv, lat);
        end
`else
        push(1'b0, 1'b1, 32'hCAFEF00D);
        issue(1'b0, 3'b010, 32'h80000002, 32'd0, 32'hCAFEF00D, 0, 0, lat, mv, a, d, s, w, st);
        checks++;
        if (a !== 32'h80000000 || lat != 3) begin
            errors++;
            $display("FAIL misalign_word: got addr=%h lat=%0d, required 80000000 3", a, lat);
        end
        push(1'b0, 1'b0, 32'd0);
        issue(1'b1, 3'b001, 32'h00000021, 32'h0000A5C3, 32'd0, 0, 0, lat, mv, a, d, s, w, st);
        checks++;
        if (a !== 32'h00000020 || s !== 4'b0011 || d !== 32'hA5C3A5C3) begin
            errors++;
            $display("FAIL misalign_half: got addr=%h strb=%b wd=%h, required 00000020 0011 A5C3A5C3", a, s, d);
        end
`endif
    endtask

    task automatic test_illegal;
        int lat, mv; logic [31:0] a, d; logic [3:0] s; logic w, st;
        logic [2:0] bad [3] = '{3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 1'b1, 32'd0);
            issue(i[0], bad[i], 32'h00000008, 32'hFFFFFFFF, 32'd0, 0, 0, lat, mv, a, d, s, w, st);
            checks++;
            if (lat != 1 || mv != 0) begin
                errors++;
                $display("FAIL illegal_op[%0d]: got lat=%0d mv_cycles=%0d, required 1 0", i, lat, mv);
            end
        end
    endtask

    task automatic test_reset_rwait;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_op = 3'b010; req_addr = 32'h00000040;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        checks++;
        if (mem_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rwait_entry: got mv=%0b rv=%0b ready=%0b, required 0 0 0", mem_valid, rsp_valid, req_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || mem_addr !== 32'd0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got ready=%0b addr=%h rv=%0b, required 1 0 0", req_ready, mem_addr, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h76543210;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL late_rvalid[%0d]: got rv=%0b ready=%0b, required 0 1", i, rsp_valid, req_ready);
            end
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_back_to_back;
        int lat, mv; logic [31:0] a, d, adr, wd, wrd, ew, er; logic [3:0] s, es; logic w, st, wen;
        logic [2:0] op; int rdy, rv, sz;
        logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < 20; n++) begin
            op  = ops[$urandom_range(0, 4)];
            wen = (op[2] == 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
            sz  = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
            adr = $urandom & ~(32'(sz) - 32'd1);
            wd  = $urandom; wrd = $urandom;
            rdy = $urandom_range(0, 3); rv = $urandom_range(0, 3);
            es = 4'b0000; ew = 32'd0;
            er = wrd >> (8 * adr[1:0]);
            for (int b = 0; b < 4; b++) begin
                if (b >= adr[1:0] && b < adr[1:0] + sz) es[b] = 1'b1;
                ew[8*b +: 8] = wd[8*(b % sz) +: 8];
            end
            if (sz == 1) er = op[2] ? (er & 32'hFF) : {{24{er[7]}}, er[7:0]};
            if (sz == 2) er = op[2] ? (er & 32'hFFFF) : {{16{er[15]}}, er[15:0]};
            if (sz == 4) er = wrd;
            push(1'b0, !wen, er);
            issue(wen, op, adr, wd, wrd, rdy, rv, lat, mv, a, d, s, w, st);
            checks++;
            if (a !== {adr[31:2], 2'b00} || w !== wen || st !== 1'b1 ||
                lat != (wen ? 2 + rdy : 3 + rdy + rv) ||
                (wen && (s !== es || d !== ew))) begin
                errors++;
                $display("FAIL b2b[%0d]: got addr=%h wen=%0b strb=%b wd=%h lat=%0d stable=%0b, required %h %0b %b %h %0d 1",
                         n, a, w, s, d, lat, st, {adr[31:2], 2'b00}, wen, es, ew, wen ? 2 + rdy : 3 + rdy + rv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_ext();
        test_stall_timeout();
        test_misalign();
        test_illegal();
        test_reset_rwait();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_rsp: got %0d pending, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
